// File: rtl/alu_pkg.sv
// ==========================================================================
// alu_pkg : ALU control codes, ALUOp encodings and R-type funct constants
// Rev 1.0 : initial release
// ==========================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100,
        ALU_NOP = 4'b1111
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_RTYP = 2'b10;
    localparam logic [1:0] ALUOP_SLTI = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// ==========================================================================
// alu_ctrl_decode : combinational ALUOp/funct to 4-bit ALU control decode
// Rev 1.0 : initial release
// ==========================================================================
`default_nettype none

module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_NOP;
        case (alu_op_i)
            ALUOP_ADD:  alu_ctrl_o = ALU_ADD;
            ALUOP_SUB:  alu_ctrl_o = ALU_SUB;
            ALUOP_SLTI: alu_ctrl_o = ALU_SLT;
            default: begin
                // Unknown funct maps to NOP so the ALU produces zero.
                case (funct_i)
                    FUNCT_ADD: alu_ctrl_o = ALU_ADD;
                    FUNCT_SUB: alu_ctrl_o = ALU_SUB;
                    FUNCT_AND: alu_ctrl_o = ALU_AND;
                    FUNCT_OR:  alu_ctrl_o = ALU_OR;
                    FUNCT_SLT: alu_ctrl_o = ALU_SLT;
                    FUNCT_NOR: alu_ctrl_o = ALU_NOR;
                    default:   alu_ctrl_o = ALU_NOP;
                endcase
            end
        endcase
    end

endmodule : alu_ctrl_decode

`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
// ==========================================================================
// id_ex_operand_stage : ID/EX register with operand forwarding and load-use detect
// Rev 1.0 : initial release
// ==========================================================================
`default_nettype none

module id_ex_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ID_Valid,
    input  logic [DATA_W-1:0] ID_RD1,
    input  logic [DATA_W-1:0] ID_RD2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [REG_W-1:0]  ID_Rs,
    input  logic [REG_W-1:0]  ID_Rt,
    input  logic [REG_W-1:0]  ID_Rd,
    input  logic [1:0]        ID_ALUOp,
    input  logic [5:0]        ID_Funct,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              EXMEM_RegWrite,
    input  logic [REG_W-1:0]  EXMEM_Rd,
    input  logic [DATA_W-1:0] EXMEM_Result,
    input  logic              MEMWB_RegWrite,
    input  logic [REG_W-1:0]  MEMWB_Rd,
    input  logic [DATA_W-1:0] MEMWB_Result,
    output logic [DATA_W-1:0] OP1,
    output logic [DATA_W-1:0] OP2,
    output logic [3:0]        ALU_Control,
    output logic [DATA_W-1:0] EX_StoreData,
    output logic              EX_Valid,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic [REG_W-1:0]  EX_WriteReg,
    output logic              LoadUseHazard
);

    logic              valid_q,    valid_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q,  memread_d;
    logic              alusrc_q,   alusrc_d;
    logic [DATA_W-1:0] rd1_q,      rd1_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [REG_W-1:0]  rs_q,       rs_d;
    logic [REG_W-1:0]  rt_q,       rt_d;
    logic [REG_W-1:0]  wreg_q,     wreg_d;
    logic [3:0]        aluctl_q,   aluctl_d;
    logic [3:0]        w_dec_ctl;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op_i   (ID_ALUOp),
        .funct_i    (ID_Funct),
        .alu_ctrl_o (w_dec_ctl)
    );

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        alusrc_d   = alusrc_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wreg_d     = wreg_q;
        aluctl_d   = aluctl_q;
        if (Flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (!Stall) begin
            // An empty decode slot still loads data but with all control dropped.
            valid_d    = ID_Valid;
            regwrite_d = ID_Valid & ID_RegWrite;
            memread_d  = ID_Valid & ID_MemRead;
            alusrc_d   = ID_ALUSrc;
            rd1_d      = ID_RD1;
            rd2_d      = ID_RD2;
            imm_d      = ID_Imm;
            rs_d       = ID_Rs;
            rt_d       = ID_Rt;
            wreg_d     = ID_RegDst ? ID_Rd : ID_Rt;
            aluctl_d   = w_dec_ctl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wreg_q     <= '0;
            aluctl_q   <= 4'b0000;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            alusrc_q   <= alusrc_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wreg_q     <= wreg_d;
            aluctl_q   <= aluctl_d;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        w_fwd_rs = rd1_q;
        if (EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == rs_q))
            w_fwd_rs = EXMEM_Result;
        else if (MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == rs_q))
            w_fwd_rs = MEMWB_Result;
    end

    always_comb begin
        w_fwd_rt = rd2_q;
        if (EXMEM_RegWrite && (EXMEM_Rd != '0) && (EXMEM_Rd == rt_q))
            w_fwd_rt = EXMEM_Result;
        else if (MEMWB_RegWrite && (MEMWB_Rd != '0) && (MEMWB_Rd == rt_q))
            w_fwd_rt = MEMWB_Result;
    end

    assign OP1          = w_fwd_rs;
    assign OP2          = alusrc_q ? imm_q : w_fwd_rt;
    assign EX_StoreData = w_fwd_rt;
    assign ALU_Control  = aluctl_q;
    assign EX_Valid     = valid_q;
    assign EX_RegWrite  = regwrite_q;
    assign EX_MemRead   = memread_q;
    assign EX_WriteReg  = wreg_q;

    assign LoadUseHazard = valid_q & memread_q & (wreg_q != '0) &
                           ((wreg_q == ID_Rs) | (wreg_q == ID_Rt));

endmodule : id_ex_operand_stage

`default_nettype wire
